lc2k_multicycle_ctrl: RTL and testbench



---
 rtl/lc2k_multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_lc2k_multicycle_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lc2k_multicycle_ctrl.sv
// Multi-cycle control FSM for the LC2K CPU (fetch/decode/exec/mem/wb over one memory port).
// Define LC2K_PERF_CNT_EN to build the cycle and retired-instruction counters.
module lc2k_multicycle_ctrl #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        alu_zero,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        ir_write,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic [1:0]  alu_op,
   output logic        alu_srcb_sel,
   output logic        reg_write,
   output logic        reg_dst_sel,
   output logic [1:0]  wb_src,
   output logic        halted,
   output logic        fault,
   output logic [2:0]  state,
   output logic [31:0] cycle_count,
   output logic [31:0] retired_count
);
   localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
   localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_FAULT = 3'd7;
   localparam logic [2:0] OP_ADD = 3'b000, OP_NOR = 3'b001, OP_LW = 3'b010, OP_SW = 3'b011;
   localparam logic [2:0] OP_BEQ = 3'b100, OP_JALR = 3'b101, OP_HALT = 3'b110, OP_NOOP = 3'b111;
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   logic [2:0] state_q, state_d;
   logic [2:0] opcode_q, opcode_d;
   logic [7:0] wait_q, wait_d;
   logic       timeout_s;
   logic       unused_s;

   assign unused_s  = ^{instr[31:25], instr[21:0]};
   assign timeout_s = !mem_ready && (wait_q == WAIT_LAST);
   assign state     = state_q;

   // State, latched opcode and wait counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         opcode_q <= 3'd0;
         wait_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         wait_q   <= wait_d;
      end
   end

   // Next-state logic; an ack on the last allowed wait cycle beats the timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH: begin
            if (mem_ready)      state_d = S_DECODE;
            else if (timeout_s) state_d = S_FAULT;
            else                state_d = S_FETCH;
         end
         S_DECODE: begin
            case (instr[24:22])
               OP_HALT: state_d = S_HALT;
               OP_NOOP: state_d = S_FETCH;
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (opcode_q)
               OP_ADD, OP_NOR: state_d = S_WB;
               OP_LW, OP_SW:   state_d = S_MEM;
               default:        state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (mem_ready)      state_d = (opcode_q == OP_SW) ? S_FETCH : S_WB;
            else if (timeout_s) state_d = S_FAULT;
            else                state_d = S_MEM;
         end
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_IDLE;
      endcase
   end

   // Opcode latch in DECODE; wait count only grows while staying in an un-acked request state
   always_comb begin
      opcode_d = opcode_q;
      wait_d   = 8'd0;
      if (state_q == S_DECODE) opcode_d = instr[24:22];
      else                     opcode_d = opcode_q;
      if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && (state_d == state_q))
         wait_d = wait_q + 8'd1;
      else
         wait_d = 8'd0;
   end

   // Output decode from state, latched opcode and inputs
   always_comb begin
      pc_write = 1'b0;  pc_src = 2'd0;  ir_write = 1'b0;  mem_req = 1'b0;
      mem_we = 1'b0;    mem_addr_sel = 1'b0;  alu_op = 2'd0;  alu_srcb_sel = 1'b0;
      reg_write = 1'b0; reg_dst_sel = 1'b0;   wb_src = 2'd0;  halted = 1'b0;
      fault = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
            pc_write = mem_ready;
         end
         S_EXEC: begin
            case (opcode_q)
               OP_NOR:       alu_op = 2'd1;
               OP_LW, OP_SW: alu_srcb_sel = 1'b1;
               OP_BEQ: begin
                  alu_op = 2'd2;
                  if (alu_zero) begin
                     pc_write = 1'b1;
                     pc_src   = 2'd1;
                  end else begin
                     pc_write = 1'b0;
                     pc_src   = 2'd0;
                  end
               end
               OP_JALR: begin
                  reg_write   = 1'b1;
                  reg_dst_sel = 1'b1;
                  wb_src      = 2'd2;
                  pc_write    = 1'b1;
                  pc_src      = 2'd2;
               end
               default: alu_op = 2'd0;
            endcase
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (opcode_q == OP_SW);
            alu_srcb_sel = 1'b1;
         end
         S_WB: begin
            reg_write = 1'b1;
            if (opcode_q == OP_LW) begin
               reg_dst_sel = 1'b1;
               wb_src      = 2'd1;
            end else begin
               reg_dst_sel = 1'b0;
               wb_src      = 2'd0;
            end
         end
         S_HALT:  halted = 1'b1;
         S_FAULT: fault  = 1'b1;
         default: pc_write = 1'b0;
      endcase
   end

`ifdef LC2K_PERF_CNT_EN
   logic [31:0] cycle_q, retired_q;
   logic        retire_s, active_s;

   assign active_s = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_FAULT);
   assign retire_s = ((state_q == S_DECODE) && (instr[24:23] == 2'b11)) ||
                     ((state_q == S_EXEC) && (opcode_q == OP_BEQ || opcode_q == OP_JALR)) ||
                     ((state_q == S_MEM) && mem_ready && (opcode_q == OP_SW)) ||
                     (state_q == S_WB);

   // Performance counters; both freeze once the FSM parks in HALT or FAULT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q   <= 32'd0;
         retired_q <= 32'd0;
      end else begin
         if (active_s) cycle_q <= cycle_q + 32'd1;
         if (retire_s) retired_q <= retired_q + 32'd1;
      end
   end

   assign cycle_count   = cycle_q;
   assign retired_count = retired_q;
`else
   assign cycle_count   = 32'd0;
   assign retired_count = 32'd0;
`endif

endmodule

// File: tb/tb_lc2k_multicycle_ctrl.sv
// Scoreboard bench for lc2k_multicycle_ctrl: per-cycle expected control vectors queued with stimulus.
module tb_lc2k_multicycle_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'd0;
   logic        mem_ready = 1'b0;
   logic        alu_zero = 1'b0;
   logic        pc_write, ir_write, mem_req, mem_we, mem_addr_sel, alu_srcb_sel;
   logic        reg_write, reg_dst_sel, halted, fault;
   logic [1:0]  pc_src, alu_op, wb_src;
   logic [2:0]  state;
   logic [31:0] cycle_count, retired_count;
   logic [18:0] obs_s;

   int n_checks = 0;
   int n_errors = 0;
   logic [18:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   lc2k_multicycle_ctrl #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
      .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .alu_op(alu_op),
      .alu_srcb_sel(alu_srcb_sel), .reg_write(reg_write), .reg_dst_sel(reg_dst_sel),
      .wb_src(wb_src), .halted(halted), .fault(fault), .state(state),
      .cycle_count(cycle_count), .retired_count(retired_count)
   );

   assign obs_s = {state, pc_write, pc_src, ir_write, mem_req, mem_we, mem_addr_sel,
                   alu_op, alu_srcb_sel, reg_write, reg_dst_sel, wb_src, halted, fault};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [18:0] ev(input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
                                      input logic irw, input logic mreq, input logic mwe,
                                      input logic masel, input logic [1:0] aop, input logic srcb,
                                      input logic rw, input logic rds, input logic [1:0] wbs);
      return {st, pcw, pcs, irw, mreq, mwe, masel, aop, srcb, rw, rds, wbs,
              st == 3'd6, st == 3'd7};
   endfunction

   function automatic logic [31:0] enc(input logic [2:0] op, input logic [2:0] a,
                                       input logic [2:0] b, input logic [15:0] off);
      return {7'd0, op, a, b, off};
   endfunction

   function automatic logic [18:0] e_fetch(input logic rdy);
      return ev(3'd1, rdy, 2'd0, rdy, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
   endfunction

   function automatic logic [18:0] e_mem(input logic we);
      return ev(3'd4, 1'b0, 2'd0, 1'b0, 1'b1, we, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
   endfunction

   function automatic logic [18:0] e_plain(input logic [2:0] st);
      return ev(st, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
   endfunction

   task automatic cyc(input logic r, input logic [31:0] ins, input logic rdy, input logic az,
                      input logic [18:0] e, input string tag);
      @(negedge clk);
      rst_n     = r;
      instr     = ins;
      mem_ready = rdy;
      alu_zero  = az;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Monitor: compare each queued expectation mid-way through the low clock phase
   initial forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) chk(tag_q.pop_front(), 64'(obs_s), 64'(exp_q.pop_front()));
   end

   initial begin
      logic [31:0] i_add, i_lw, i_beq, i_jalr, i_sw, i_noop, i_nor, i_halt;
      i_add  = enc(3'b000, 3'd1, 3'd2, 16'd3);
      i_nor  = enc(3'b001, 3'd3, 3'd4, 16'd5);
      i_lw   = enc(3'b010, 3'd0, 3'd1, 16'd7);
      i_sw   = enc(3'b011, 3'd0, 3'd2, 16'd9);
      i_beq  = enc(3'b100, 3'd1, 3'd1, 16'hFFFE);
      i_jalr = enc(3'b101, 3'd4, 3'd5, 16'd0);
      i_halt = enc(3'b110, 3'd0, 3'd0, 16'd0);
      i_noop = enc(3'b111, 3'd0, 3'd0, 16'd0);

      cyc(1'b0, i_add, 1'b1, 1'b0, e_plain(3'd0), "reset");
      cyc(1'b1, i_add, 1'b1, 1'b0, e_plain(3'd0), "idle");
      // add 1,2,3 with zero-latency memory
      cyc(1'b1, i_add, 1'b1, 1'b0, e_fetch(1'b1), "add_fetch");
      cyc(1'b1, i_add, 1'b1, 1'b0, e_plain(3'd2), "add_dec");
      cyc(1'b1, i_add, 1'b1, 1'b0, e_plain(3'd3), "add_exec");
      cyc(1'b1, i_add, 1'b1, 1'b0,
          ev(3'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0), "add_wb");
      // lw with two wait cycles in both FETCH and MEM
      cyc(1'b1, i_lw, 1'b0, 1'b0, e_fetch(1'b0), "lw_fetch0");
      cyc(1'b1, i_lw, 1'b0, 1'b0, e_fetch(1'b0), "lw_fetch1");
      cyc(1'b1, i_lw, 1'b1, 1'b0, e_fetch(1'b1), "lw_fetch2");
      cyc(1'b1, i_lw, 1'b0, 1'b0, e_plain(3'd2), "lw_dec");
      cyc(1'b1, i_lw, 1'b0, 1'b0,
          ev(3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0), "lw_exec");
      cyc(1'b1, i_lw, 1'b0, 1'b0, e_mem(1'b0), "lw_mem0");
      cyc(1'b1, i_lw, 1'b0, 1'b0, e_mem(1'b0), "lw_mem1");
      cyc(1'b1, i_lw, 1'b1, 1'b0, e_mem(1'b0), "lw_mem2");
      cyc(1'b1, i_lw, 1'b1, 1'b0,
          ev(3'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd1), "lw_wb");
      // beq taken, then not taken
      cyc(1'b1, i_beq, 1'b1, 1'b0, e_fetch(1'b1), "beq_fetch");
      cyc(1'b1, i_beq, 1'b1, 1'b0, e_plain(3'd2), "beq_dec");
      cyc(1'b1, i_beq, 1'b1, 1'b1,
          ev(3'd3, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0), "beq_taken");
      cyc(1'b1, i_beq, 1'b1, 1'b0, e_fetch(1'b1), "beq2_fetch");
      cyc(1'b1, i_beq, 1'b1, 1'b0, e_plain(3'd2), "beq2_dec");
      cyc(1'b1, i_beq, 1'b1, 1'b0,
          ev(3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0), "beq_nt");
      // jalr 4,5
      cyc(1'b1, i_jalr, 1'b1, 1'b0, e_fetch(1'b1), "jalr_fetch");
      cyc(1'b1, i_jalr, 1'b1, 1'b0, e_plain(3'd2), "jalr_dec");
      cyc(1'b1, i_jalr, 1'b1, 1'b0,
          ev(3'd3, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd2), "jalr_exec");
      // sw, noop, nor
      cyc(1'b1, i_sw, 1'b1, 1'b0, e_fetch(1'b1), "sw_fetch");
      cyc(1'b1, i_sw, 1'b1, 1'b0, e_plain(3'd2), "sw_dec");
      cyc(1'b1, i_sw, 1'b1, 1'b0,
          ev(3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0), "sw_exec");
      cyc(1'b1, i_sw, 1'b1, 1'b0, e_mem(1'b1), "sw_mem");
      cyc(1'b1, i_noop, 1'b1, 1'b0, e_fetch(1'b1), "noop_fetch");
      cyc(1'b1, i_noop, 1'b1, 1'b0, e_plain(3'd2), "noop_dec");
      cyc(1'b1, i_nor, 1'b1, 1'b0, e_fetch(1'b1), "nor_fetch");
      cyc(1'b1, i_nor, 1'b1, 1'b0, e_plain(3'd2), "nor_dec");
      cyc(1'b1, i_nor, 1'b1, 1'b0,
          ev(3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0), "nor_exec");
      cyc(1'b1, i_nor, 1'b1, 1'b0,
          ev(3'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0), "nor_wb");
      // lw whose MEM access never acks: four request cycles, then FAULT
      cyc(1'b1, i_lw, 1'b1, 1'b0, e_fetch(1'b1), "to_fetch");
      cyc(1'b1, i_lw, 1'b0, 1'b0, e_plain(3'd2), "to_dec");
      cyc(1'b1, i_lw, 1'b0, 1'b0,
          ev(3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0), "to_exec");
      for (int i = 0; i < 4; i++) cyc(1'b1, i_lw, 1'b0, 1'b0, e_mem(1'b0), "to_mem");
      cyc(1'b1, i_lw, 1'b0, 1'b0, e_plain(3'd7), "fault");
      cyc(1'b1, i_lw, 1'b1, 1'b0, e_plain(3'd7), "fault_sticky");
      // ack on the last allowed FETCH wait cycle completes normally, then halt
      cyc(1'b0, i_halt, 1'b0, 1'b0, e_plain(3'd0), "rst2");
      cyc(1'b1, i_halt, 1'b0, 1'b0, e_plain(3'd0), "idle2");
      for (int i = 0; i < 3; i++) cyc(1'b1, i_halt, 1'b0, 1'b0, e_fetch(1'b0), "edge_wait");
      cyc(1'b1, i_halt, 1'b1, 1'b0, e_fetch(1'b1), "edge_ack");
      cyc(1'b1, i_halt, 1'b0, 1'b0, e_plain(3'd2), "halt_dec");
      for (int i = 0; i < 20; i++) cyc(1'b1, i_halt, i[0], 1'b1, e_plain(3'd6), "halt");
      #3;
`ifdef LC2K_PERF_CNT_EN
      chk("halt_cycles", 64'(cycle_count), 64'd5);
      chk("halt_retired", 64'(retired_count), 64'd1);
`else
      chk("cycles_tied", 64'(cycle_count), 64'd0);
      chk("retired_tied", 64'(retired_count), 64'd0);
`endif
      // reset asserted in the middle of an sw MEM access
      cyc(1'b0, i_sw, 1'b1, 1'b0, e_plain(3'd0), "rst3");
      cyc(1'b1, i_sw, 1'b1, 1'b0, e_plain(3'd0), "idle3");
      cyc(1'b1, i_sw, 1'b1, 1'b0, e_fetch(1'b1), "sw3_fetch");
      cyc(1'b1, i_sw, 1'b0, 1'b0, e_plain(3'd2), "sw3_dec");
      cyc(1'b1, i_sw, 1'b0, 1'b0,
          ev(3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0), "sw3_exec");
      cyc(1'b1, i_sw, 1'b0, 1'b0, e_mem(1'b1), "sw3_mem");
      cyc(1'b0, i_sw, 1'b0, 1'b0, e_plain(3'd0), "rst_mid_mem");
      cyc(1'b1, i_sw, 1'b0, 1'b0, e_plain(3'd0), "idle4");
      cyc(1'b1, i_sw, 1'b0, 1'b0, e_fetch(1'b0), "fetch4");

      @(negedge clk);
      #3;
      chk("drain", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
